// File: rtl/arctan_lut_arbiter.sv
// arctan_lut_arbiter: round-robin sharing of one arctan LUT between pan and tilt paths
module arctan_lut_arbiter #(
  parameter int LUT_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pan_req,
  input  logic [10:0] pan_idx,
  output logic        pan_ack,
  output logic        pan_valid,
  output logic [7:0]  pan_angle,
  input  logic        tilt_req,
  input  logic [10:0] tilt_idx,
  output logic        tilt_ack,
  output logic        tilt_valid,
  output logic [7:0]  tilt_angle,
  output logic [10:0] lut_in,
  input  logic [7:0]  lut_out,
  output logic        busy
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t     state;
  logic       last, owner, pick_pan;
  logic [2:0] cnt;
  always_comb pick_pan = pan_req & (~tilt_req | last);
  assign busy = state == WAIT;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= '0;
      lut_in     <= '0;
      last       <= 1'b1;
      owner      <= 1'b0;
      pan_ack    <= 1'b0;
      tilt_ack   <= 1'b0;
      pan_valid  <= 1'b0;
      tilt_valid <= 1'b0;
      pan_angle  <= '0;
      tilt_angle <= '0;
    end else begin
      pan_ack    <= 1'b0;
      tilt_ack   <= 1'b0;
      pan_valid  <= 1'b0;
      tilt_valid <= 1'b0;
      if (state == IDLE) begin
        if (pan_req | tilt_req) begin
          lut_in   <= pick_pan ? pan_idx : tilt_idx;
          pan_ack  <= pick_pan;
          tilt_ack <= ~pick_pan;
          cnt      <= 3'(LUT_LAT);
          owner    <= ~pick_pan;
          last     <= ~pick_pan;
          state    <= WAIT;
        end
      end else if (cnt != 3'd0) begin
        cnt <= cnt - 3'd1;
      end else begin
        if (owner) begin
          tilt_angle <= lut_out;
          tilt_valid <= 1'b1;
        end else begin
          pan_angle <= lut_out;
          pan_valid <= 1'b1;
        end
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_arctan_lut_arbiter.sv
// tb_arctan_lut_arbiter: directed scoreboard bench for LUT_LAT=1 and LUT_LAT=3 instances
module tb_arctan_lut_arbiter;
  logic clk = 1'b0, reset = 1'b0;
  logic pr_a, tr_a, pak_a, tak_a, pv_a, tv_a, busy_a;
  logic [10:0] pi_a, ti_a, li_a;
  logic [7:0] pang_a, tang_a, lo_a;
  logic pr_b, tr_b, pak_b, tak_b, pv_b, tv_b, busy_b;
  logic [10:0] pi_b, ti_b, li_b;
  logic [7:0] pang_b, tang_b, lo_b, s1_b, s2_b;
  typedef struct {int d; int ch; logic [7:0] ang; int cyc;} sb_t;
  sb_t q[$];
  int nchk = 0, nerr = 0, cyc = 0, e0;
  logic [7:0] mang[2][2];

  arctan_lut_arbiter #(.LUT_LAT(1)) dut_a (
    .clk(clk), .reset(reset),
    .pan_req(pr_a), .pan_idx(pi_a), .pan_ack(pak_a), .pan_valid(pv_a), .pan_angle(pang_a),
    .tilt_req(tr_a), .tilt_idx(ti_a), .tilt_ack(tak_a), .tilt_valid(tv_a), .tilt_angle(tang_a),
    .lut_in(li_a), .lut_out(lo_a), .busy(busy_a));
  arctan_lut_arbiter #(.LUT_LAT(3)) dut_b (
    .clk(clk), .reset(reset),
    .pan_req(pr_b), .pan_idx(pi_b), .pan_ack(pak_b), .pan_valid(pv_b), .pan_angle(pang_b),
    .tilt_req(tr_b), .tilt_idx(ti_b), .tilt_ack(tak_b), .tilt_valid(tv_b), .tilt_angle(tang_b),
    .lut_in(li_b), .lut_out(lo_b), .busy(busy_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) lo_a <= li_a[10:3];
  always @(posedge clk) begin
    s1_b <= li_b[10:3];
    s2_b <= s1_b;
    lo_b <= s2_b;
  end

  task automatic chk(input string n, input int act, input int exp);
    nchk++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic mon(input int d, input logic pak, pv, tak, tv, input logic [7:0] pa, ta);
    sb_t e;
    int ch;
    chk($sformatf("excl_dut%0d", d), int'(((pak | pv) & (tak | tv)) | (pak & pv) | (tak & tv)), 0);
    if (pv | tv) begin
      ch = int'(tv);
      if (q.size() == 0) begin
        nchk++;
        nerr++;
        $display("FAIL sb_unexpected: dut%0d chan %0d valid, expected none (cycle %0d)", d, ch, cyc);
      end else begin
        e = q.pop_front();
        chk("sb_dut", d, e.d);
        chk("sb_chan", ch, e.ch);
        chk("sb_cycle", cyc, e.cyc);
        chk("sb_angle", ch != 0 ? ta : pa, e.ang);
        mang[d][ch] = e.ang;
        chk("sb_other_angle", ch != 0 ? pa : ta, mang[d][1-ch]);
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, pak_a, pv_a, tak_a, tv_a, pang_a, tang_a);
    mon(1, pak_b, pv_b, tak_b, tv_b, pang_b, tang_b);
  end

  task automatic rst_pulse;
    @(negedge clk);
    reset = 1'b0;
    mang = '{default: '0};
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    {pr_a, tr_a, pr_b, tr_b} = '0;
    {pi_a, ti_a, pi_b, ti_b} = '0;
    mang = '{default: '0};
    repeat (2) @(negedge clk);
    chk("rst_busy", busy_a, 0);
    chk("rst_lut_in", li_a, 0);
    chk("rst_acks", {pak_a, tak_a, pv_a, tv_a}, 0);
    chk("rst_angles", {pang_a, tang_a}, 0);
    reset = 1'b1;
    // single pan lookup
    pi_a = 11'h400; pr_a = 1'b1;
    @(negedge clk); e0 = cyc;
    chk("t1_ack", pak_a, 1);
    chk("t1_lut_in", li_a, 'h400);
    chk("t1_busy0", busy_a, 1);
    pr_a = 1'b0;
    q.push_back('{d: 0, ch: 0, ang: 8'h80, cyc: e0 + 2});
    @(negedge clk);
    chk("t1_ack_once", pak_a, 0);
    chk("t1_busy1", busy_a, 1);
    @(negedge clk);
    chk("t1_busy2", busy_a, 0);
    repeat (2) @(negedge clk);
    // tie after reset: pan first, tilt stays pending
    rst_pulse();
    pi_a = 11'h7F8; ti_a = 11'h008; pr_a = 1'b1; tr_a = 1'b1;
    @(negedge clk); e0 = cyc;
    chk("t2_grant_pan", {pak_a, tak_a}, 2);
    pr_a = 1'b0;
    q.push_back('{d: 0, ch: 0, ang: 8'hFF, cyc: e0 + 2});
    repeat (3) @(negedge clk);
    chk("t2_grant_tilt", {pak_a, tak_a}, 1);
    chk("t2_lut_in", li_a, 'h008);
    tr_a = 1'b0;
    q.push_back('{d: 0, ch: 1, ang: 8'h01, cyc: e0 + 5});
    repeat (4) @(negedge clk);
    // continuous contention
    pi_a = 11'h123; ti_a = 11'h456; pr_a = 1'b1; tr_a = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 0) begin
        e0 = cyc;
        for (int j = 0; j < 4; j++)
          q.push_back('{d: 0, ch: j % 2, ang: (j % 2 != 0) ? 8'h8A : 8'h24, cyc: e0 + 2 + 3 * j});
      end
      chk($sformatf("t3_grant_k%0d", k), {pak_a, tak_a}, (k % 6 == 0) ? 2 : (k % 6 == 3) ? 1 : 0);
      if (k == 11) begin pr_a = 1'b0; tr_a = 1'b0; end
    end
    repeat (3) @(negedge clk);
    // single busy channel: tilt only, pointer already on tilt
    ti_a = 11'h3FF; tr_a = 1'b1;
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      if (k == 0) begin
        e0 = cyc;
        for (int j = 0; j < 3; j++) q.push_back('{d: 0, ch: 1, ang: 8'h7F, cyc: e0 + 2 + 3 * j});
      end
      chk($sformatf("t4_grant_k%0d", k), {pak_a, tak_a}, (k % 3 == 0) ? 1 : 0);
      if (k == 8) tr_a = 1'b0;
    end
    repeat (3) @(negedge clk);
    // reset during WAIT
    pi_a = 11'h200; pr_a = 1'b1;
    @(negedge clk);
    chk("t5_ack", pak_a, 1);
    pr_a = 1'b0;
    reset = 1'b0;
    mang = '{default: '0};
    #1;
    chk("t5_rst_busy", busy_a, 0);
    chk("t5_rst_lut_in", li_a, 0);
    chk("t5_rst_flags", {pak_a, tak_a, pv_a, tv_a}, 0);
    chk("t5_rst_angles", {pang_a, tang_a}, 0);
    repeat (2) @(negedge clk);
    chk("t5_no_valid", {pv_a, tv_a}, 0);
    reset = 1'b1;
    pi_a = 11'h100; pr_a = 1'b1;
    @(negedge clk); e0 = cyc;
    chk("t5_fresh_ack", pak_a, 1);
    pr_a = 1'b0;
    q.push_back('{d: 0, ch: 0, ang: 8'h20, cyc: e0 + 2});
    repeat (3) @(negedge clk);
    // longer table latency on the LUT_LAT=3 instance
    pi_b = 11'h555; ti_b = 11'h0F0; pr_b = 1'b1; tr_b = 1'b1;
    @(negedge clk); e0 = cyc;
    chk("t6_grant_pan", {pak_b, tak_b}, 2);
    chk("t6_lut_in", li_b, 'h555);
    pr_b = 1'b0;
    q.push_back('{d: 1, ch: 0, ang: 8'hAA, cyc: e0 + 4});
    repeat (3) @(negedge clk);
    chk("t6_busy_late", busy_b, 1);
    repeat (2) @(negedge clk);
    chk("t6_grant_tilt", {pak_b, tak_b}, 1);
    tr_b = 1'b0;
    q.push_back('{d: 1, ch: 1, ang: 8'h1E, cyc: e0 + 9});
    repeat (6) @(negedge clk);
    chk("sb_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
